// File: rtl/riscv_pkg.sv
// Shared definitions for the ID/EX stage: datapath widths, RV32I opcode and
// funct3 constants, ALU control codes and the EX control-bit decode helper.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // RV32I major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // funct3 encodings of the integer ALU group
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // ALU control codes
    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_SRL   = 4'b0100,
        ALU_SRA   = 4'b0101,
        ALU_OR    = 4'b0110,
        ALU_AND   = 4'b0111,
        ALU_PASSB = 4'b1000
    } alu_ctrl_e;

    // Control bits carried down the pipe with each instruction
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
    } ctrl_t;

    // Unknown opcodes decode to all-zero control, i.e. a harmless bubble.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_REG, OP_IMM, OP_AUIPC, OP_LUI: c.reg_write = 1'b1;
            OP_LOAD: begin
                c.reg_write = 1'b1;
                c.mem_read  = 1'b1;
            end
            OP_STORE:  c.mem_write = 1'b1;
            OP_BRANCH: c.branch    = 1'b1;
            OP_JAL, OP_JALR: begin
                c.reg_write = 1'b1;
                c.jump      = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/idex_stage_if.sv
// Signal bundle between the ID stage / hazard unit / later pipeline stages
// (master side) and the ID/EX stage (slave side).
// Handshake: Valid_i qualifies the ID fields on every rising edge; there is no
// ready signal -- back-pressure is expressed by Stall_i (hold) and squashing by
// Flush_i (bubble), both driven by the hazard unit. Valid_o qualifies every
// registered output towards EX.
interface idex_stage_if #(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
);
    // ID / hazard unit inputs
    logic                  Stall_i;
    logic                  Flush_i;
    logic                  Valid_i;
    logic [XLEN-1:0]       PC_i;
    logic [6:0]            Opcode_i;
    logic [2:0]            Funct3_i;
    logic                  Funct7b5_i;
    logic [REG_ADDR_W-1:0] Rs1Addr_i;
    logic [REG_ADDR_W-1:0] Rs2Addr_i;
    logic [REG_ADDR_W-1:0] RdAddr_i;
    logic [XLEN-1:0]       Rs1Data_i;
    logic [XLEN-1:0]       Rs2Data_i;
    logic [XLEN-1:0]       Imm_i;
    logic                  PredTaken_i;
    // Forwarding sources
    logic                  ExMemRegWrite_i;
    logic [REG_ADDR_W-1:0] ExMemRd_i;
    logic [XLEN-1:0]       ExMemData_i;
    logic                  MemWbRegWrite_i;
    logic [REG_ADDR_W-1:0] MemWbRd_i;
    logic [XLEN-1:0]       MemWbData_i;
    // Stage outputs
    logic [XLEN-1:0]       OperandA_o;
    logic [XLEN-1:0]       OperandB_o;
    logic [3:0]            ALUCtrl_o;
    logic [XLEN-1:0]       Rs1Fwd_o;
    logic [XLEN-1:0]       Rs2Fwd_o;
    logic [XLEN-1:0]       PC_o;
    logic [XLEN-1:0]       Imm_o;
    logic [REG_ADDR_W-1:0] RdAddr_o;
    logic [2:0]            Funct3_o;
    logic                  Valid_o;
    logic                  RegWrite_o;
    logic                  MemRead_o;
    logic                  MemWrite_o;
    logic                  Branch_o;
    logic                  Jump_o;
    logic                  PredTaken_o;
    logic                  SetLess_o;
    logic                  SetLessU_o;
    logic                  LoadUseStall_o;

    modport master (
        output Stall_i, Flush_i, Valid_i, PC_i, Opcode_i, Funct3_i, Funct7b5_i,
               Rs1Addr_i, Rs2Addr_i, RdAddr_i, Rs1Data_i, Rs2Data_i, Imm_i,
               PredTaken_i, ExMemRegWrite_i, ExMemRd_i, ExMemData_i,
               MemWbRegWrite_i, MemWbRd_i, MemWbData_i,
        input  OperandA_o, OperandB_o, ALUCtrl_o, Rs1Fwd_o, Rs2Fwd_o, PC_o,
               Imm_o, RdAddr_o, Funct3_o, Valid_o, RegWrite_o, MemRead_o,
               MemWrite_o, Branch_o, Jump_o, PredTaken_o, SetLess_o,
               SetLessU_o, LoadUseStall_o
    );

    modport slave (
        input  Stall_i, Flush_i, Valid_i, PC_i, Opcode_i, Funct3_i, Funct7b5_i,
               Rs1Addr_i, Rs2Addr_i, RdAddr_i, Rs1Data_i, Rs2Data_i, Imm_i,
               PredTaken_i, ExMemRegWrite_i, ExMemRd_i, ExMemData_i,
               MemWbRegWrite_i, MemWbRd_i, MemWbData_i,
        output OperandA_o, OperandB_o, ALUCtrl_o, Rs1Fwd_o, Rs2Fwd_o, PC_o,
               Imm_o, RdAddr_o, Funct3_o, Valid_o, RegWrite_o, MemRead_o,
               MemWrite_o, Branch_o, Jump_o, PredTaken_o, SetLess_o,
               SetLessU_o, LoadUseStall_o
    );

endinterface

// File: rtl/alu_ctrl_decoder.sv
// Combinational ALU control decode.
// Ports: opcode/funct3/funct7b5 in; alu_ctrl (4-bit code), set_less and
// set_less_u (SLT/SLTU requests to the comparator) out.
module alu_ctrl_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_ctrl,
    output logic       set_less,
    output logic       set_less_u
);

    logic is_reg;
    logic is_imm;

    assign is_reg = (opcode == OP_REG);
    assign is_imm = (opcode == OP_IMM);

    always_comb begin
        alu_ctrl   = ALU_ADD;
        set_less   = 1'b0;
        set_less_u = 1'b0;
        if (opcode == OP_LUI) begin
            alu_ctrl = ALU_PASSB;
        end else if (is_reg || is_imm) begin
            case (funct3)
                // instr[30] in an I-type ADDI is immediate bit 10, never SUB
                F3_ADD_SUB: alu_ctrl = (is_reg && funct7b5) ? ALU_SUB : ALU_ADD;
                F3_SLL:     alu_ctrl = ALU_SLL;
                F3_XOR:     alu_ctrl = ALU_XOR;
                // SRAI keeps instr[30] as the arithmetic flag, so no is_reg gate
                F3_SR:      alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                F3_OR:      alu_ctrl = ALU_OR;
                F3_AND:     alu_ctrl = ALU_AND;
                // Set-less compares use the subtractor; the comparator picks the flavour
                F3_SLT: begin
                    alu_ctrl = ALU_SUB;
                    set_less = 1'b1;
                end
                F3_SLTU: begin
                    alu_ctrl   = ALU_SUB;
                    set_less_u = 1'b1;
                end
                default: alu_ctrl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with EX-side operand preparation.
// Ports: clk_i, rst_ni (async active-low) and the idex_stage_if slave bundle:
// ID fields + stall/flush in, EX/MEM and MEM/WB forwarding sources in;
// ALU operands/control, forwarded rs1/rs2, registered fields/control and the
// combinational load-use hazard flag out.
module idex_stage #(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    idex_stage_if.slave  bus
);
    import riscv_pkg::*;

    ctrl_t                 dec;
    logic                  valid_q;
    ctrl_t                 ctrl_q;
    logic                  pred_taken_q;
    logic [XLEN-1:0]       pc_q;
    logic [XLEN-1:0]       imm_q;
    logic [6:0]            opcode_q;
    logic [2:0]            funct3_q;
    logic                  f7b5_q;
    logic [REG_ADDR_W-1:0] rs1_addr_q;
    logic [REG_ADDR_W-1:0] rs2_addr_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       rs1_data_q;
    logic [XLEN-1:0]       rs2_data_q;

    logic [XLEN-1:0]       rs1_fwd;
    logic [XLEN-1:0]       rs2_fwd;
    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    logic [3:0]            alu_ctrl;
    logic                  set_less;
    logic                  set_less_u;

    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [XLEN-1:0]       stored,
        input logic                  ex_we,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic [XLEN-1:0]       ex_data,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [XLEN-1:0]       wb_data
    );
        if (ex_we && (ex_rd != '0) && (ex_rd == src))
            return ex_data;
        else if (wb_we && (wb_rd != '0) && (wb_rd == src))
            return wb_data;
        else
            return stored;
    endfunction

    assign dec = decode_ctrl(bus.Opcode_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            pred_taken_q <= 1'b0;
            pc_q         <= '0;
            imm_q        <= '0;
            opcode_q     <= '0;
            funct3_q     <= '0;
            f7b5_q       <= 1'b0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rd_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
        end else if (bus.Flush_i) begin
            // Bubble: kill control only, datapath fields are don't-care and hold
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            pred_taken_q <= 1'b0;
        end else if (bus.Stall_i) begin
            // Re-capture forwarded values so they outlive their producer
            rs1_data_q <= rs1_fwd;
            rs2_data_q <= rs2_fwd;
        end else begin
            valid_q      <= bus.Valid_i;
            ctrl_q       <= bus.Valid_i ? dec : '0;
            pred_taken_q <= bus.Valid_i & bus.PredTaken_i;
            pc_q         <= bus.PC_i;
            imm_q        <= bus.Imm_i;
            opcode_q     <= bus.Opcode_i;
            funct3_q     <= bus.Funct3_i;
            f7b5_q       <= bus.Funct7b5_i;
            rs1_addr_q   <= bus.Rs1Addr_i;
            rs2_addr_q   <= bus.Rs2Addr_i;
            rd_q         <= bus.RdAddr_i;
            rs1_data_q   <= bus.Rs1Data_i;
            rs2_data_q   <= bus.Rs2Data_i;
        end
    end

    always_comb begin
        rs1_fwd = fwd_sel(rs1_addr_q, rs1_data_q,
                          bus.ExMemRegWrite_i, bus.ExMemRd_i, bus.ExMemData_i,
                          bus.MemWbRegWrite_i, bus.MemWbRd_i, bus.MemWbData_i);
        rs2_fwd = fwd_sel(rs2_addr_q, rs2_data_q,
                          bus.ExMemRegWrite_i, bus.ExMemRd_i, bus.ExMemData_i,
                          bus.MemWbRegWrite_i, bus.MemWbRd_i, bus.MemWbData_i);
    end

    // Unknown opcodes fall through to rs1/rs2, which read 0 out of reset.
    always_comb begin
        operand_a = rs1_fwd;
        operand_b = rs2_fwd;
        case (opcode_q)
            OP_IMM, OP_LOAD, OP_STORE, OP_JALR: operand_b = imm_q;
            OP_BRANCH, OP_JAL, OP_AUIPC: begin
                operand_a = pc_q;
                operand_b = imm_q;
            end
            OP_LUI: begin
                operand_a = '0;
                operand_b = imm_q;
            end
            default: ;
        endcase
    end

    alu_ctrl_decoder u_alu_ctrl_decoder (
        .opcode     (opcode_q),
        .funct3     (funct3_q),
        .funct7b5   (f7b5_q),
        .alu_ctrl   (alu_ctrl),
        .set_less   (set_less),
        .set_less_u (set_less_u)
    );

    assign bus.OperandA_o  = operand_a;
    assign bus.OperandB_o  = operand_b;
    assign bus.ALUCtrl_o   = alu_ctrl;
    assign bus.SetLess_o   = set_less;
    assign bus.SetLessU_o  = set_less_u;
    assign bus.Rs1Fwd_o    = rs1_fwd;
    assign bus.Rs2Fwd_o    = rs2_fwd;
    assign bus.PC_o        = pc_q;
    assign bus.Imm_o       = imm_q;
    assign bus.RdAddr_o    = rd_q;
    assign bus.Funct3_o    = funct3_q;
    assign bus.Valid_o     = valid_q;
    assign bus.RegWrite_o  = ctrl_q.reg_write;
    assign bus.MemRead_o   = ctrl_q.mem_read;
    assign bus.MemWrite_o  = ctrl_q.mem_write;
    assign bus.Branch_o    = ctrl_q.branch;
    assign bus.Jump_o      = ctrl_q.jump;
    assign bus.PredTaken_o = pred_taken_q;

    // A load in EX whose result the ID instruction needs cannot be forwarded in time.
    assign bus.LoadUseStall_o = valid_q && ctrl_q.mem_read && (rd_q != '0) &&
                                bus.Valid_i &&
                                ((rd_q == bus.Rs1Addr_i) || (rd_q == bus.Rs2Addr_i));

endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- ID/EX pipeline register plus EX-side operand preparation.
- Captures decoded fields from ID and applies EX/MEM and MEM/WB forwarding.
- Drives OperandA, OperandB and the 4-bit ALU control code straight into the ALU.
- Also provides forwarded rs1/rs2 to the branch comparator and store path, and flags load-use hazards to the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- Stall_i  in  1  hold stage contents.
- Flush_i  in  1  insert bubble; priority over Stall_i.
- Valid_i  in  1  ID instruction valid.
- PC_i  in  XLEN  ID PC.
- Opcode_i  in  7  ID opcode.
- Funct3_i  in  3  ID funct3.
- Funct7b5_i  in  1  instr[30].
- Rs1Addr_i, Rs2Addr_i, RdAddr_i  in  REG_ADDR_W  ID register indices.
- Rs1Data_i, Rs2Data_i  in  XLEN  register-file read data.
- Imm_i  in  XLEN  sign-extended immediate.
- PredTaken_i  in  1  branch-predictor decision for this instruction.
- ExMemRegWrite_i  in  1  EX/MEM writes a register.
- ExMemRd_i  in  REG_ADDR_W  EX/MEM destination.
- ExMemData_i  in  XLEN  EX/MEM result.
- MemWbRegWrite_i  in  1  MEM/WB writes a register.
- MemWbRd_i  in  REG_ADDR_W  MEM/WB destination.
- MemWbData_i  in  XLEN  MEM/WB result.
- OperandA_o, OperandB_o  out  XLEN  ALU operands.
- ALUCtrl_o  out  4  ALU code.
- Rs1Fwd_o, Rs2Fwd_o  out  XLEN  forwarded register values.
- PC_o, Imm_o  out  XLEN  registered copies.
- RdAddr_o  out  REG_ADDR_W  registered destination.
- Funct3_o  out  3  registered funct3.
- Valid_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o, PredTaken_o  out  1  registered control.
- SetLess_o, SetLessU_o  out  1  SLT/SLTU request to the comparator.
- LoadUseStall_o  out  1  combinational hazard flag.

Behaviour:
- Reset: every register clears to 0, so all outputs read 0. With ALUCtrl_o=0000 and operands 0, the ALU result is 0.
- Capture:
  - Each rising edge with Flush_i=0 and Stall_i=0 latches all ID inputs.
  - Control bits are decoded from Opcode_i at capture and ANDed with Valid_i.
  - Latency is 1 cycle from ID to outputs.
- Flush_i=1:
  - Next edge clears Valid, RegWrite, MemRead, MemWrite, Branch, Jump and PredTaken.
  - Datapath fields hold. This applies even when Stall_i=1.
- Stall_i=1, Flush_i=0:
  - Control and addresses hold.
  - Stored rs1/rs2 data is overwritten with the current Rs1Fwd_o/Rs2Fwd_o, so a forwarded value survives its producer retiring.
- Forwarding (combinational, per source register):
  - EX/MEM is used if ExMemRegWrite_i, ExMemRd_i≠0 and it matches the source index.
  - Otherwise MEM/WB is used under the same conditions.
  - Otherwise the stored register data is used.
  - EX/MEM wins when both match. Index x0 never forwards.
- Operand select by stored opcode:
  - R-type 0110011: A=rs1, B=rs2.
  - I-ALU 0010011, load 0000011, store 0100011, JALR 1100111: A=rs1, B=imm.
  - Branch 1100011, JAL 1101111, AUIPC 0010111: A=PC, B=imm.
  - LUI 0110111: A=0, B=imm.
- ALUCtrl_o:
  - Load, store, branch, JAL, JALR and AUIPC: 0000 (add).
  - LUI: 1000 (pass B).
  - R-type and I-ALU, by funct3:
    - 000: 0000, or 0001 when R-type with f7b5=1. I-type never subtracts.
    - 001: 0010.
    - 100: 0011.
    - 101: 0100, or 0101 when f7b5=1.
    - 110: 0110.
    - 111: 0111.
    - 010 and 011: 0001, with SetLess_o or SetLessU_o set respectively.
  - Unknown opcode: 0000 with RegWrite, MemRead, MemWrite, Branch and Jump all 0.
- RegWrite: set for R, I-ALU, load, JAL, JALR, LUI and AUIPC.
- LoadUseStall_o:
  - Asserted when Valid_o, MemRead_o, RdAddr_o≠0, and RdAddr_o equals Rs1Addr_i or Rs2Addr_i with Valid_i=1.
  - The hazard unit responds by stalling IF/ID and asserting Flush_i here.
- Reset asserted mid-operation: clears immediately. No partial state survives.

Decomposition:
- Package riscv_pkg:
  - opcode constants;
  - ALUCtrl codes 0000–1000 (ADD, SUB, SLL, XOR, SRL, SRA, OR, AND, PASSB);
  - funct3 constants;
  - XLEN.
- Sub-module alu_ctrl_decoder: combinational {opcode, funct3, f7b5} → {ALUCtrl, SetLess, SetLessU}.

Test Plan:
- Reset check: deassert rst_ni mid-run → all outputs 0 in the same cycle; first capture after release is correct.
- SUB then SRAI:
  - R-type f3=000, f7b5=1, rs1=10, rs2=3 → ALUCtrl_o=0001, A=10, B=3.
  - I-type f3=101, f7b5=1 → 0101, B=imm.
- Forward priority: ExMem(rd=5, 0xAAAA) and MemWb(rd=5, 0xBBBB), instruction rs1=5 → OperandA_o=0xAAAA. With rd=0 on both → stored data.
- Load-use: LW x7 in EX, ID ADD rs2=x7 → LoadUseStall_o=1. Flush_i next edge → Valid_o=0, RegWrite_o=0.
- Stall refresh: EX holds ADD rs1=x9 with MemWb forwarding 0x1234; assert Stall_i, then MemWb moves on → OperandA_o stays 0x1234.
- LUI/AUIPC/branch:
  - LUI imm=0x12345000 → A=0, B=imm, ALUCtrl_o=1000.
  - BEQ at PC=0x100, imm=8, PredTaken_i=1 → A=0x100, B=8, Branch_o=1, PredTaken_o=1.
  - Same with Flush_i=1 → PredTaken_o=0.
